vga_sync_gen: RTL



---
 rtl/vga_sync_gen_pkg.sv | 27 ++
 rtl/vga_sync_gen_if.sv | 31 +++
 rtl/vga_sync_gen_tick.sv | 33 +++
 rtl/vga_sync_gen.sv | 108 ++++++++++
 4 files changed

// File: rtl/vga_sync_gen_pkg.sv
// Shared raster timing constants for the VGA sync generator (default 640x480 @ 60 Hz).
package vga_timing_pkg;

    localparam int COORD_W = 10;

    localparam int DEF_CLK_DIV   = 4;
    localparam int DEF_H_DISPLAY = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_DISPLAY = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;

    localparam int H_TOTAL = DEF_H_DISPLAY + DEF_H_FRONT + DEF_H_SYNC + DEF_H_BACK;
    localparam int V_TOTAL = DEF_V_DISPLAY + DEF_V_FRONT + DEF_V_SYNC + DEF_V_BACK;

    // SYNC_POL encoding: the level a sync output takes while active
    localparam bit SYNC_ACTIVE_LOW  = 1'b0;
    localparam bit SYNC_ACTIVE_HIGH = 1'b1;

    function automatic logic sync_level(input bit pol, input logic active);
        return active ? pol : ~pol;
    endfunction

endpackage

// File: rtl/vga_sync_gen_if.sv
// Raster timing bundle driven by vga_sync_gen; frame_count exists only with VGA_FRAME_COUNT_EN.
interface vga_sync_gen_if;
    import vga_timing_pkg::*;

    logic [COORD_W-1:0] HCount;
    logic [COORD_W-1:0] VCount;
    logic               hsync;
    logic               vsync;
    logic               video_on;
    logic               pixel_tick;
    logic               line_start;
    logic               frame_start;
`ifdef VGA_FRAME_COUNT_EN
    logic [7:0]         frame_count;
`endif

    modport master (
        output HCount, VCount, hsync, vsync, video_on, pixel_tick, line_start, frame_start
`ifdef VGA_FRAME_COUNT_EN
        , output frame_count
`endif
    );

    modport slave (
        input HCount, VCount, hsync, vsync, video_on, pixel_tick, line_start, frame_start
`ifdef VGA_FRAME_COUNT_EN
        , input frame_count
`endif
    );

endinterface

// File: rtl/vga_sync_gen_tick.sv
// Pixel clock-enable divider: pixel_tick is high on the last phase of each CLK_DIV-cycle period.
module pixel_tick_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    output logic pixel_tick
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    generate
        if (CLK_DIV < 1) begin : g_bad_div
            $error("pixel_tick_gen: CLK_DIV must be >= 1");
        end
    endgenerate

    logic [DIV_W-1:0] r_div;

    // With CLK_DIV=1 the counter sits at 0 == DIV_LAST, so the tick is constant.
    always_ff @(posedge clk) begin
        if (reset)
            r_div <= '0;
        else if (pixel_tick)
            r_div <= '0;
        else
            r_div <= r_div + 1'b1;
    end

    assign pixel_tick = (r_div == DIV_LAST);

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster counter and sync generator. Optional frame counter output under VGA_FRAME_COUNT_EN.
module vga_sync_gen
    import vga_timing_pkg::*;
#(
    parameter int CLK_DIV   = DEF_CLK_DIV,
    parameter int H_DISPLAY = DEF_H_DISPLAY,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_DISPLAY = DEF_V_DISPLAY,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK,
    parameter bit SYNC_POL  = SYNC_ACTIVE_LOW
) (
    input  logic           clk,
    input  logic           reset,
    vga_sync_gen_if.master vga
);

    localparam int HT = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
    localparam int VT = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
    localparam int HS_LO = H_DISPLAY + H_FRONT;
    localparam int HS_HI = H_DISPLAY + H_FRONT + H_SYNC - 1;
    localparam int VS_LO = V_DISPLAY + V_FRONT;
    localparam int VS_HI = V_DISPLAY + V_FRONT + V_SYNC - 1;
    localparam logic [COORD_W-1:0] H_LAST = COORD_W'(HT - 1);
    localparam logic [COORD_W-1:0] V_LAST = COORD_W'(VT - 1);

    generate
        if (HT > 1024 || VT > 1024) begin : g_bad_total
            $error("vga_sync_gen: H_TOTAL and V_TOTAL must be <= 1024");
        end
    endgenerate

    logic               w_tick;
    logic [COORD_W-1:0] w_h_nxt;
    logic [COORD_W-1:0] w_v_nxt;

    logic [COORD_W-1:0] r_h;
    logic [COORD_W-1:0] r_v;
    logic               r_hs;
    logic               r_vs;
    logic               r_vid;
    logic               r_ls;
    logic               r_fs;

    pixel_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
        .clk        (clk),
        .reset      (reset),
        .pixel_tick (w_tick)
    );

    always_comb begin
        w_h_nxt = (r_h == H_LAST) ? '0 : r_h + 1'b1;
        w_v_nxt = r_v;
        if (r_h == H_LAST)
            w_v_nxt = (r_v == V_LAST) ? '0 : r_v + 1'b1;
    end

    // Decodes are taken from the next coordinates so every output matches the counters it lands with.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_h   <= '0;
            r_v   <= '0;
            r_hs  <= sync_level(SYNC_POL, 1'b0);
            r_vs  <= sync_level(SYNC_POL, 1'b0);
            r_vid <= 1'b0;
            r_ls  <= 1'b0;
            r_fs  <= 1'b0;
        end else begin
            r_ls <= 1'b0;
            r_fs <= 1'b0;
            if (w_tick) begin
                r_h   <= w_h_nxt;
                r_v   <= w_v_nxt;
                r_hs  <= sync_level(SYNC_POL, int'(w_h_nxt) >= HS_LO && int'(w_h_nxt) <= HS_HI);
                r_vs  <= sync_level(SYNC_POL, int'(w_v_nxt) >= VS_LO && int'(w_v_nxt) <= VS_HI);
                r_vid <= (int'(w_h_nxt) < H_DISPLAY) && (int'(w_v_nxt) < V_DISPLAY);
                r_ls  <= (w_h_nxt == '0);
                r_fs  <= (w_h_nxt == '0) && (w_v_nxt == '0);
            end
        end
    end

`ifdef VGA_FRAME_COUNT_EN
    logic [7:0] r_fc;

    always_ff @(posedge clk) begin
        if (reset)
            r_fc <= '0;
        else if (w_tick && w_h_nxt == '0 && w_v_nxt == '0)
            r_fc <= r_fc + 1'b1;
    end

    assign vga.frame_count = r_fc;
`endif

    assign vga.HCount      = r_h;
    assign vga.VCount      = r_v;
    assign vga.hsync       = r_hs;
    assign vga.vsync       = r_vs;
    assign vga.video_on    = r_vid;
    assign vga.pixel_tick  = w_tick;
    assign vga.line_start  = r_ls;
    assign vga.frame_start = r_fs;

endmodule
